// File: rtl/mem_port_arbiter.sv
// Four-core arbiter for one shared single-port memory; one access in flight at a time.
// Round-robin by default; define MEM_ARB_FIXED_PRIORITY_EN for fixed priority (core 0 highest).
module mem_port_arbiter #(
    parameter int unsigned N = 17
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   req,
    input  logic [3:0]   we,
    input  logic [11:0]  addr1,
    input  logic [11:0]  addr2,
    input  logic [11:0]  addr3,
    input  logic [11:0]  addr4,
    input  logic [N-1:0] datain1,
    input  logic [N-1:0] datain2,
    input  logic [N-1:0] datain3,
    input  logic [N-1:0] datain4,
    output logic [3:0]   gnt,
    output logic [3:0]   rvalid,
    output logic [11:0]  rdata,
    output logic         mem_en,
    output logic         mem_we,
    output logic [11:0]  mem_addr,
    output logic [11:0]  mem_wdata,
    input  logic [11:0]  mem_rdata,
    output logic         busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [1:0]  sel_idx, idx_q;
    logic        we_q;
    logic [11:0] sel_addr, sel_wdata;
    logic [11:0] addr_q, wdata_q, rdata_q;

`ifdef MEM_ARB_FIXED_PRIORITY_EN
    always_comb begin
        sel_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) sel_idx = 2'(i);
        end
    end
`else
    logic [1:0] last_grant_q;

    // Scan the search order backwards so the first requester after last_grant wins.
    always_comb begin
        sel_idx = 2'd0;
        for (int i = 4; i >= 1; i--) begin
            if (req[last_grant_q + 2'(i)]) sel_idx = last_grant_q + 2'(i);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 2'd3;
        end else if (state_q == StIssue) begin
            last_grant_q <= idx_q;
        end
    end
`endif

    always_comb begin
        sel_addr  = addr1;
        sel_wdata = datain1[11:0];
        unique case (sel_idx)
            2'd0: begin sel_addr = addr1; sel_wdata = datain1[11:0]; end
            2'd1: begin sel_addr = addr2; sel_wdata = datain2[11:0]; end
            2'd2: begin sel_addr = addr3; sel_wdata = datain3[11:0]; end
            2'd3: begin sel_addr = addr4; sel_wdata = datain4[11:0]; end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (req != 4'b0) state_d = StIssue;
            StIssue: state_d = we_q ? StIdle : StWait;
            StWait:  state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q   <= 2'd0;
            we_q    <= 1'b0;
            addr_q  <= 12'h0;
            wdata_q <= 12'h0;
            rdata_q <= 12'h0;
        end else begin
            if (state_q == StIdle && req != 4'b0) begin
                idx_q   <= sel_idx;
                we_q    <= we[sel_idx];
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
            end
            if (state_q == StWait) rdata_q <= mem_rdata;
        end
    end

    always_comb begin
        gnt       = 4'b0;
        rvalid    = 4'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 12'h0;
        mem_wdata = 12'h0;
        case (state_q)
            StIssue: begin
                gnt       = 4'b0001 << idx_q;
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
            end
            StResp:  rvalid = 4'b0001 << idx_q;
            default: ;
        endcase
    end

    assign rdata = rdata_q;
    assign busy  = (state_q != StIdle);

    // Only the low 12 bits of the write bus are stored.
    if (N > 12) begin : g_unused_upper
        logic unused_upper;
        assign unused_upper = ^{datain1[N-1:12], datain2[N-1:12], datain3[N-1:12],
                                datain4[N-1:12]};
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: transaction-level reference model predicts
// grants and read data, a negedge monitor compares whatever the DUT presents.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int N = 17;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   req = 4'b0;
    logic [3:0]   we = 4'b0;
    logic [11:0]  addr [4];
    logic [N-1:0] din [4];
    logic [3:0]   gnt, rvalid;
    logic [11:0]  rdata, mem_addr, mem_wdata, mem_rdata;
    logic         mem_en, mem_we, busy;

    mem_port_arbiter #(.N(N)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we),
        .addr1(addr[0]), .addr2(addr[1]), .addr3(addr[2]), .addr4(addr[3]),
        .datain1(din[0]), .datain2(din[1]), .datain3(din[2]), .datain4(din[3]),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] init_word(input logic [11:0] a);
        return a ^ 12'h00D;
    endfunction

    // Registered single-port RAM attached to the memory side
    logic [11:0] ram [int];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[int'(mem_addr)] = mem_wdata;
            else mem_rdata <= ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)]
                                                          : init_word(mem_addr);
        end
    end

    typedef struct {
        logic [1:0]  core;
        logic        w;
        logic [11:0] a;
        logic [11:0] d;
        int          gcyc;
    } txn_t;

    txn_t        gq[$];
    txn_t        rq[$];
    logic [3:0]  glog_gnt[$];
    int          glog_cyc[$];
    logic [11:0] ref_mem [int];
    int          cyc = 0;
    int          free_at = 0;
    int          last = 3;
    int          total = 0;
    int          bad = 0;
    int          m_w;
    txn_t        m_t;
    txn_t        e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: arbiter is free again 2 cycles after a write decision, 4 after a read.
    initial forever begin
        @(posedge clk);
        cyc++;
        if (reset) begin
            last = 3;
            free_at = 0;
            gq.delete();
            rq.delete();
        end else if (cyc >= free_at && req != 4'b0) begin
            m_w = -1;
`ifdef MEM_ARB_FIXED_PRIORITY_EN
            for (int i = 0; i < 4; i++) if (m_w < 0 && req[i]) m_w = i;
`else
            for (int i = 1; i <= 4; i++) if (m_w < 0 && req[(last + i) % 4]) m_w = (last + i) % 4;
`endif
            m_t.core = 2'(m_w);
            m_t.w    = we[m_w];
            m_t.a    = addr[m_w];
            m_t.d    = din[m_w][11:0];
            m_t.gcyc = cyc;
            if (m_t.w) ref_mem[int'(m_t.a)] = m_t.d;
            else m_t.d = ref_mem.exists(int'(m_t.a)) ? ref_mem[int'(m_t.a)] : init_word(m_t.a);
            gq.push_back(m_t);
            free_at = cyc + (m_t.w ? 2 : 4);
            last = m_w;
        end
    end

    // Monitor
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            chk("busy", 32'(busy), 32'(cyc + 1 < free_at));
            if (gnt != 4'b0 || mem_en) begin
                if (gq.size() == 0) begin
                    chk("unexpected gnt/mem_en", 32'({mem_en, gnt}), 0);
                end else begin
                    e = gq.pop_front();
                    glog_gnt.push_back(gnt);
                    glog_cyc.push_back(cyc);
                    chk("gnt", 32'(gnt), 32'(4'b0001 << e.core));
                    chk("gnt cycle", cyc, e.gcyc);
                    chk("mem_en", 32'(mem_en), 1);
                    chk("mem_we", 32'(mem_we), 32'(e.w));
                    chk("mem_addr", 32'(mem_addr), 32'(e.a));
                    if (e.w) chk("mem_wdata", 32'(mem_wdata), 32'(e.d));
                    else rq.push_back(e);
                end
            end else begin
                chk("idle strobes", 32'({mem_en, mem_we}), 0);
                if (gq.size() != 0 && cyc > gq[0].gcyc) begin
                    chk("missing gnt cycle", cyc, gq[0].gcyc);
                    void'(gq.pop_front());
                end
            end
            if (rvalid != 4'b0) begin
                if (rq.size() == 0) begin
                    chk("unexpected rvalid", 32'(rvalid), 0);
                end else begin
                    e = rq.pop_front();
                    chk("rvalid", 32'(rvalid), 32'(4'b0001 << e.core));
                    chk("rdata", 32'(rdata), 32'(e.d));
                    chk("rvalid cycle", cyc, e.gcyc + 2);
                end
            end else if (rq.size() != 0 && cyc > rq[0].gcyc + 2) begin
                chk("missing rvalid cycle", cyc, rq[0].gcyc + 2);
                void'(rq.pop_front());
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, " gnt"}, 32'(gnt), 0);
        chk({tag, " rvalid"}, 32'(rvalid), 0);
        chk({tag, " rdata"}, 32'(rdata), 0);
        chk({tag, " mem_en"}, 32'(mem_en), 0);
        chk({tag, " mem_we"}, 32'(mem_we), 0);
        chk({tag, " mem_addr"}, 32'(mem_addr), 0);
        chk({tag, " mem_wdata"}, 32'(mem_wdata), 0);
        chk({tag, " busy"}, 32'(busy), 0);
    endtask

    task automatic wait_gnt(input int c, output int at);
        int n;
        n = 0;
        at = -1;
        while (n < 30) begin
            @(negedge clk);
            if (gnt[c]) begin
                at = cyc;
                break;
            end
            n++;
        end
        if (n >= 30) chk("gnt timeout", 32'(n), 0);
    endtask

    task automatic do_req(input int c, input logic w, input logic [11:0] a,
                          input logic [N-1:0] d);
        int at;
        req[c] = 1'b1; we[c] = w; addr[c] = a; din[c] = d;
        wait_gnt(c, at);
        @(posedge clk); #1;
        req[c] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic new_req(input int i);
        req[i]  = 1'b1;
        we[i]   = 1'($urandom_range(1));
        addr[i] = 12'($urandom_range(31));
        din[i]  = N'($urandom);
    endtask

    task automatic run_random(input int ncyc);
        logic [3:0] g;
        for (int t = 0; t < ncyc; t++) begin
            @(negedge clk);
            g = gnt;
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) begin
                if (req[i] && g[i]) begin
                    if ($urandom_range(1) == 1) new_req(i);
                    else req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(3) == 0) begin
                    new_req(i);
                end
            end
        end
        req = 4'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    logic [3:0] exp_order [5];
    int base, c1, g2, rv, at;

    initial begin
        for (int i = 0; i < 4; i++) begin
            addr[i] = 12'h0;
            din[i]  = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        reset = 1'b0;

        // Read from core 0: mem_rdata is 005 at address 008
        do_req(0, 1'b0, 12'h008, '0);
        // Write from core 2 keeps only the low 12 bits, then read it back from core 3
        do_req(2, 1'b1, 12'h204, 17'h1_0ABC);
        do_req(3, 1'b0, 12'h204, '0);

        // All four reading, held: order from reset state
        do_reset();
`ifdef MEM_ARB_FIXED_PRIORITY_EN
        exp_order = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
        base = glog_gnt.size();
        for (int i = 0; i < 4; i++) addr[i] = 12'h010 + 12'(i);
        we = 4'b0;
        req = 4'b1111;
        for (int n = 0; n < 80 && glog_gnt.size() < base + 5; n++) @(negedge clk);
        @(posedge clk); #1;
        req = 4'b0;
        if (glog_gnt.size() < base + 5) begin
            chk("held-req grant count", 32'(glog_gnt.size() - base), 5);
        end else begin
            for (int k = 0; k < 5; k++) chk("held-req order", 32'(glog_gnt[base + k]), 32'(exp_order[k]));
            for (int k = 1; k < 5; k++) chk("held-req spacing", 32'(glog_cyc[base + k] - glog_cyc[base + k - 1]), 4);
        end
        repeat (6) @(posedge clk);
        #1;

        // Reset while waiting on read data: everything clears, no rvalid follows
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 12'h033;
        wait_gnt(0, at);
        @(posedge clk); #1;
        req[0] = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        chk_zero("reset in wait");
        @(posedge clk); #1;
        reset = 1'b0;
        do_req(1, 1'b0, 12'h044, '0);

        // Core 2 requests while core 1's read is in WAIT
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 12'h055;
        wait_gnt(1, c1);
        @(posedge clk); #1;
        req[1] = 1'b0;
        req[2] = 1'b1; we[2] = 1'b0; addr[2] = 12'h066;
        rv = -100;
        g2 = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (rvalid[1]) rv = cyc;
            if (gnt[2]) begin
                g2 = cyc;
                break;
            end
        end
        chk("rvalid-to-next-gnt gap", 32'(g2 - rv), 2);
        @(posedge clk); #1;
        req[2] = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        run_random(3000);

        chk("grant queue drained", 32'(gq.size()), 0);
        chk("read queue drained", 32'(rq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter N, default 17, requester write-data width (bus width); only bits [11:0] are stored.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req  input  4  per-core access request, held high until gnt.
REQ-005 SHALL have port we  input  4  per-core write enable, qualifies req.
REQ-006 SHALL have ports addr1..addr4  input  12 each  per-core word address.
REQ-007 SHALL have ports datain1..datain4  input  N each  per-core write data.
REQ-008 SHALL have port gnt  output  4  one-hot, one-cycle acceptance pulse.
REQ-009 SHALL have port rvalid  output  4  one-hot, one-cycle read-data-valid pulse.
REQ-010 SHALL have port rdata  output  12  read data, shared by all cores, qualified by rvalid.
REQ-011 SHALL have ports mem_en / mem_we  output  1 each  memory access strobe / write strobe.
REQ-012 SHALL have ports mem_addr / mem_wdata  output  12 each  memory address / write data.
REQ-013 SHALL have port mem_rdata  input  12  registered memory output, valid one cycle after the mem_en cycle.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-016 IDLE: with req==0, SHALL remain in IDLE; otherwise SHALL select one winner, latch its index, we, addr and datain[11:0], and go to ISSUE.
REQ-017 Winner selection SHALL be round-robin: search starts at (last_grant+1) mod 4 and wraps through 3->0.
REQ-018 ISSUE: SHALL assert mem_en=1, mem_we=latched we, mem_addr/mem_wdata=latched values, gnt[idx]=1, and update last_grant=idx.
REQ-019 ISSUE exit: a write SHALL go to IDLE; a read SHALL go to WAIT.
REQ-020 WAIT: SHALL register mem_rdata into rdata and go to RESP.
REQ-021 RESP: SHALL assert rvalid[idx]=1 with rdata stable, then go to IDLE.
REQ-022 Latency: read SHALL be req sampled in IDLE at edge T -> gnt in cycle T+1 -> rvalid in cycle T+3; write SHALL be gnt in cycle T+1 with the memory write at the end of T+1.
REQ-023 Back-to-back: SHALL always pass through IDLE, so minimum spacing is 2 cycles per write and 4 cycles per read.
REQ-024 mem_en, mem_we and gnt SHALL be 0 outside ISSUE; rvalid SHALL be 0 outside RESP.
REQ-025 Requests arriving or dropping outside IDLE SHALL be ignored until the next IDLE; a req dropped after latching SHALL still complete.
REQ-026 rdata SHALL hold its last value until the next WAIT.
REQ-027 Simultaneous req on all four with last_grant=1 SHALL grant in order 2,3,0,1.

Reset
REQ-028 reset SHALL asynchronously force state=IDLE, last_grant=3 (so core 0 has first priority), and gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy all to 0.
REQ-029 Reset during ISSUE/WAIT/RESP SHALL abort the transaction; no gnt or rvalid pulse SHALL follow for it.

Configuration
REQ-030 SHALL honour macro MEM_ARB_FIXED_PRIORITY_EN.
REQ-031 With the macro defined, selection SHALL be fixed priority (core 0 highest, core 3 lowest) and last_grant SHALL not be used.
REQ-032 Without the macro, selection SHALL be round-robin per REQ-017.

Verification
REQ-033 Reset release, req=4'b0001, we=0, addr1=12'h008, mem_rdata=12'h005 -> gnt=0001 at T+1, mem_addr=008, rvalid=0001 with rdata=005 at T+3.
REQ-034 req=4'b0100, we=4'b0100, addr3=12'h204, datain3=17'h1_0ABC -> mem_en=mem_we=1, mem_addr=204, mem_wdata=ABC, gnt=0100 in one cycle, no rvalid.
REQ-035 req=4'b1111 held, all reads -> grants in order 0,1,2,3,0 at 4-cycle spacing; with MEM_ARB_FIXED_PRIORITY_EN, only core 0 is granted while its req stays high.
REQ-036 Read accepted, reset asserted in WAIT -> all outputs 0 immediately, no rvalid; next req=0010 granted from IDLE.
REQ-037 Core 1 reading while core 2 raises req during WAIT -> core 2 gnt no earlier than 2 cycles after core 1 rvalid.
